dcache_plru_victim: RTL and testbench



---
 rtl/dcache_plru_victim.sv | 206 ++++++++++++++++++++
 tb/tb_dcache_plru_victim.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_plru_victim.sv
// Tree-PLRU victim selector for the D$ miss path, with per-set occupancy tracking.
// Optional build macro DCACHE_PLRU_STATS_EN adds saturating request/conflict counters.
module dcache_plru_victim #(
    parameter int WAYS  = 2,
    parameter int SETS  = 128,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             evict_req_valid_i,
    input  logic [IDX_W-1:0] evict_set_i,
    output logic             evict_req_ready_o,
    output logic             evict_resp_valid_o,
    output logic [WAY_W-1:0] evict_way_o,
    output logic             victim_valid_o,
    input  logic             touch_valid_i,
    input  logic [IDX_W-1:0] touch_set_i,
    input  logic [WAY_W-1:0] touch_way_i,
    input  logic             fill_valid_i,
    input  logic [IDX_W-1:0] fill_set_i,
    input  logic [WAY_W-1:0] fill_way_i,
    input  logic             flush_i,
    output logic             busy_o
`ifdef DCACHE_PLRU_STATS_EN
    ,
    output logic [31:0]      req_cnt_o,
    output logic [31:0]      conflict_cnt_o
`endif
);

    localparam int TREE_W = WAYS - 1;

    typedef enum logic [1:0] {
        CLEAR,
        READY,
        RESP
    } state_t;

    // Heap-ordered walk: each level's node bit selects the half holding the victim.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [TREE_W-1:0] tree);
        logic [WAY_W-1:0]  way;
        logic [TREE_W-1:0] sh;
        int                node;
        way  = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            sh   = tree >> node;
            way  = (way << 1) | WAY_W'(sh[0]);
            node = 2 * node + 1 + (sh[0] ? 1 : 0);
        end
        return way;
    endfunction

    function automatic logic [TREE_W-1:0] plru_update(input logic [TREE_W-1:0] tree,
                                                      input logic [WAY_W-1:0]  way);
        logic [TREE_W-1:0] t;
        logic [WAY_W-1:0]  wsh;
        logic              b;
        int                node;
        t    = tree;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            wsh  = way << l;
            b    = wsh[WAY_W-1];
            t    = (t & ~(TREE_W'(1) << node)) | (TREE_W'(!b) << node);
            node = 2 * node + 1 + (b ? 1 : 0);
        end
        return t;
    endfunction

    logic [TREE_W-1:0] r_tree [SETS];
    logic [WAYS-1:0]   r_occ  [SETS];

    state_t            r_state;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_ready;
    logic              r_resp_valid;
    logic [WAY_W-1:0]  r_way;
    logic              r_victim_valid;
    logic              r_busy;

    logic [TREE_W-1:0] w_tree;
    logic [WAYS-1:0]   w_occ;
    logic              w_has_empty;
    logic [WAY_W-1:0]  w_empty_way;
    logic [WAY_W-1:0]  w_vict_way;
    logic              w_accept;
    logic              w_upd_en;

    assign w_tree      = r_tree[evict_set_i];
    assign w_occ       = r_occ[evict_set_i];
    assign w_has_empty = ~&w_occ;
    assign w_accept    = (r_state == READY) && evict_req_valid_i && !flush_i;
    assign w_upd_en    = (r_state != CLEAR) && !flush_i;

    // Descending scan so the lowest empty way is the last one written.
    always_comb begin
        w_empty_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (((w_occ >> i) & WAYS'(1)) == '0) begin
                w_empty_way = WAY_W'(i);
            end
        end
        w_vict_way = w_has_empty ? w_empty_way : plru_victim(w_tree);
    end

    // Fill is written after touch so it wins when both hit the same set.
    always_ff @(posedge clk_i) begin
        if (r_state == CLEAR) begin
            r_tree[r_cnt] <= '0;
            r_occ[r_cnt]  <= '0;
        end else if (w_upd_en) begin
            if (touch_valid_i) begin
                r_tree[touch_set_i] <= plru_update(r_tree[touch_set_i], touch_way_i);
            end
            if (fill_valid_i) begin
                r_tree[fill_set_i] <= plru_update(r_tree[fill_set_i], fill_way_i);
                r_occ[fill_set_i]  <= r_occ[fill_set_i] | (WAYS'(1) << fill_way_i);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= CLEAR;
            r_cnt          <= '0;
            r_ready        <= 1'b0;
            r_resp_valid   <= 1'b0;
            r_way          <= '0;
            r_victim_valid <= 1'b0;
            r_busy         <= 1'b1;
        end else if (flush_i) begin
            r_state      <= CLEAR;
            r_cnt        <= '0;
            r_ready      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b1;
        end else begin
            case (r_state)
                CLEAR: begin
                    if (r_cnt == IDX_W'(SETS - 1)) begin
                        r_state <= READY;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                READY: begin
                    if (evict_req_valid_i) begin
                        r_state        <= RESP;
                        r_ready        <= 1'b0;
                        r_resp_valid   <= 1'b1;
                        r_way          <= w_vict_way;
                        r_victim_valid <= !w_has_empty;
                    end
                end
                RESP: begin
                    r_state      <= READY;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b0;
                end
                default: begin
                    r_state <= CLEAR;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign evict_req_ready_o  = r_ready;
    assign evict_resp_valid_o = r_resp_valid;
    assign evict_way_o        = r_way;
    assign victim_valid_o     = r_victim_valid;
    assign busy_o             = r_busy;

`ifdef DCACHE_PLRU_STATS_EN
    logic [31:0] r_req_cnt;
    logic [31:0] r_conflict_cnt;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_cnt      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_accept && (r_req_cnt != '1)) begin
                r_req_cnt <= r_req_cnt + 32'd1;
            end
            if (r_resp_valid && r_victim_valid && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    assign req_cnt_o      = r_req_cnt;
    assign conflict_cnt_o = r_conflict_cnt;
`else
    logic w_unused;
    assign w_unused = w_accept;
`endif

endmodule

// File: tb/tb_dcache_plru_victim.sv
// Directed bench for dcache_plru_victim: a 2-way and a 4-way instance share one stimulus stream.
module tb_dcache_plru_victim;

    localparam int SETS = 128;
    localparam int OP_FILL   = 0;
    localparam int OP_TOUCH  = 1;
    localparam int OP_EVICT  = 2;
    localparam int OP_EVFILL = 3;
    localparam int OP_TF     = 4;

    typedef struct {
        int         op;
        logic [6:0] set;
        logic [1:0] tw;
        logic [1:0] fw;
        logic [1:0] e2w;
        logic       e2v;
        logic [1:0] e4w;
        logic       e4v;
    } vec_t;

    vec_t vecs[$];
    int   tests    = 0;
    int   fails    = 0;
    int   exp_req  = 0;
    int   exp_conf = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_v;
    logic [6:0] req_set;
    logic       t_v;
    logic [6:0] t_set;
    logic [1:0] t_way;
    logic       f_v;
    logic [6:0] f_set;
    logic [1:0] f_way;
    logic       flush;

    logic       rdy2, rv2, vv2, busy2;
    logic [0:0] way2;
    logic       rdy4, rv4, vv4, busy4;
    logic [1:0] way4;
`ifdef DCACHE_PLRU_STATS_EN
    logic [31:0] req_cnt2, conf_cnt2, req_cnt4, conf_cnt4;
`endif

    always #5 clk = ~clk;

    dcache_plru_victim #(.WAYS(2), .SETS(SETS)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n),
        .evict_req_valid_i(req_v), .evict_set_i(req_set),
        .evict_req_ready_o(rdy2), .evict_resp_valid_o(rv2),
        .evict_way_o(way2), .victim_valid_o(vv2),
        .touch_valid_i(t_v), .touch_set_i(t_set), .touch_way_i(t_way[0:0]),
        .fill_valid_i(f_v), .fill_set_i(f_set), .fill_way_i(f_way[0:0]),
        .flush_i(flush), .busy_o(busy2)
`ifdef DCACHE_PLRU_STATS_EN
        , .req_cnt_o(req_cnt2), .conflict_cnt_o(conf_cnt2)
`endif
    );

    dcache_plru_victim #(.WAYS(4), .SETS(SETS)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .evict_req_valid_i(req_v), .evict_set_i(req_set),
        .evict_req_ready_o(rdy4), .evict_resp_valid_o(rv4),
        .evict_way_o(way4), .victim_valid_o(vv4),
        .touch_valid_i(t_v), .touch_set_i(t_set), .touch_way_i(t_way),
        .fill_valid_i(f_v), .fill_set_i(f_set), .fill_way_i(f_way),
        .flush_i(flush), .busy_o(busy4)
`ifdef DCACHE_PLRU_STATS_EN
        , .req_cnt_o(req_cnt4), .conflict_cnt_o(conf_cnt4)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input int op, input logic [6:0] set, input logic [1:0] tw,
                       input logic [1:0] fw, input logic [1:0] e2w, input logic e2v,
                       input logic [1:0] e4w, input logic e4v);
        vec_t v;
        v.op = op; v.set = set; v.tw = tw; v.fw = fw;
        v.e2w = e2w; v.e2v = e2v; v.e4w = e4w; v.e4v = e4v;
        vecs.push_back(v);
    endtask

    task automatic sweep(input string name);
        int n;
        int bad;
        n   = 0;
        bad = 0;
        while (busy2 === 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (busy2 === 1'b1 && (rdy2 !== 1'b0 || rdy4 !== 1'b0)) bad++;
            if (busy4 !== busy2) bad++;
        end
        check({name, "_cycles"}, 32'(n), 32'd128);
        check({name, "_rdy_low"}, 32'(bad), 32'd0);
        check({name, "_rdy_after"}, 32'({rdy2, rdy4}), 32'b11);
    endtask

    task automatic do_evict(input string name, input logic [6:0] s, input logic with_fill,
                            input logic [1:0] fw, input logic [1:0] e2w, input logic e2v,
                            input logic [1:0] e4w, input logic e4v);
        @(negedge clk);
        check({name, "_ready"}, 32'({rdy2, rdy4}), 32'b11);
        req_v   = 1'b1;
        req_set = s;
        if (with_fill) begin
            f_v   = 1'b1;
            f_set = s;
            f_way = fw;
        end
        @(posedge clk);
        #1;
        req_v = 1'b0;
        f_v   = 1'b0;
        exp_req++;
        if (e2v) exp_conf++;
        check({name, "_resp"}, 32'({rv2, rv4}), 32'b11);
        check({name, "_way2"}, 32'(way2), 32'(e2w[0]));
        check({name, "_vv2"}, 32'(vv2), 32'(e2v));
        check({name, "_way4"}, 32'(way4), 32'(e4w));
        check({name, "_vv4"}, 32'(vv4), 32'(e4v));
        @(posedge clk);
        #1;
        check({name, "_pulse_end"}, 32'({rv2, rv4, rdy2, rdy4}), 32'b0011);
        check({name, "_hold"}, 32'({way2, vv2, way4, vv4}), 32'({e2w[0], e2v, e4w, e4v}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_v = 1'b0; req_set = '0; t_v = 1'b0; t_set = '0; t_way = '0;
        f_v = 1'b0; f_set = '0; f_way = '0; flush = 1'b0;

        // Directed vectors: op, set, touch way, fill way, 2-way exp, 4-way exp.
        add(OP_EVICT,  7'd5,  2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_FILL,   7'd5,  2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_EVICT,  7'd5,  2'd0, 2'd0, 2'd1, 1'b0, 2'd1, 1'b0);
        add(OP_FILL,   7'd5,  2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_EVICT,  7'd5,  2'd0, 2'd0, 2'd0, 1'b1, 2'd2, 1'b0);
        add(OP_TOUCH,  7'd5,  2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_EVICT,  7'd5,  2'd0, 2'd0, 2'd1, 1'b1, 2'd2, 1'b0);
        add(OP_EVICT,  7'd3,  2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_FILL,   7'd3,  2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_FILL,   7'd3,  2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_FILL,   7'd3,  2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_FILL,   7'd3,  2'd0, 2'd3, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_TOUCH,  7'd3,  2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_EVICT,  7'd3,  2'd0, 2'd0, 2'd1, 1'b1, 2'd2, 1'b1);
        add(OP_EVFILL, 7'd9,  2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_EVICT,  7'd9,  2'd0, 2'd0, 2'd1, 1'b0, 2'd1, 1'b0);
        add(OP_FILL,   7'd12, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_FILL,   7'd12, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_FILL,   7'd12, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_FILL,   7'd12, 2'd0, 2'd3, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_TF,     7'd12, 2'd0, 2'd3, 2'd0, 1'b0, 2'd0, 1'b0);
        add(OP_EVICT,  7'd12, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 1'b1);

        #23;
        check("reset_ready", 32'({rdy2, rdy4}), 32'b00);
        check("reset_resp", 32'({rv2, rv4}), 32'b00);
        check("reset_way_vv", 32'({way2, vv2, way4, vv4}), 32'd0);
        check("reset_busy", 32'({busy2, busy4}), 32'b11);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("reset_sweep");

        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_EVICT: do_evict($sformatf("vec%0d", i), vecs[i].set, 1'b0, 2'd0,
                                   vecs[i].e2w, vecs[i].e2v, vecs[i].e4w, vecs[i].e4v);
                OP_EVFILL: do_evict($sformatf("vec%0d", i), vecs[i].set, 1'b1, vecs[i].fw,
                                    vecs[i].e2w, vecs[i].e2v, vecs[i].e4w, vecs[i].e4v);
                default: begin
                    @(negedge clk);
                    if (vecs[i].op == OP_TOUCH || vecs[i].op == OP_TF) begin
                        t_v = 1'b1; t_set = vecs[i].set; t_way = vecs[i].tw;
                    end
                    if (vecs[i].op == OP_FILL || vecs[i].op == OP_TF) begin
                        f_v = 1'b1; f_set = vecs[i].set; f_way = vecs[i].fw;
                    end
                    @(posedge clk);
                    #1;
                    t_v = 1'b0;
                    f_v = 1'b0;
                end
            endcase
        end

        // Flush during the response cycle aborts it and restarts the sweep.
        @(negedge clk);
        check("flush_pre_ready", 32'({rdy2, rdy4}), 32'b11);
        req_v = 1'b1; req_set = 7'd5;
        @(posedge clk);
        #1;
        req_v = 1'b0;
        exp_req++;
        exp_conf++;
        check("flush_resp_seen", 32'({rv2, rv4}), 32'b11);
        check("flush_resp_vals", 32'({way2, vv2, way4, vv4}), 32'({1'b1, 1'b1, 2'd2, 1'b0}));
        @(negedge clk);
        flush = 1'b1;
        f_v = 1'b1; f_set = 7'd5; f_way = 2'd0;
        @(posedge clk);
        #1;
        flush = 1'b0;
        f_v = 1'b0;
        check("flush_resp_abort", 32'({rv2, rv4}), 32'b00);
        check("flush_busy", 32'({busy2, busy4, rdy2, rdy4}), 32'b1100);
        sweep("flush_sweep");
        do_evict("post_flush_s5", 7'd5, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
        do_evict("post_flush_s3", 7'd3, 1'b0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);

`ifdef DCACHE_PLRU_STATS_EN
        check("stats_req2", req_cnt2, 32'(exp_req));
        check("stats_conf2", conf_cnt2, 32'(exp_conf));
`endif

        // Asynchronous reset in the middle of a response.
        @(negedge clk);
        req_v = 1'b1; req_set = 7'd3;
        @(posedge clk);
        #1;
        req_v = 1'b0;
        check("areset_resp_before", 32'({rv2, rv4}), 32'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_outputs", 32'({rv2, rv4, rdy2, rdy4, busy2, busy4}), 32'b000011);
`ifdef DCACHE_PLRU_STATS_EN
        check("areset_stats", req_cnt2 | conf_cnt2, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
